// File: rtl/line_draw_arbiter.sv
// line_draw_arbiter: round-robin owner of a single line_drawer that forwards its pixels as framebuffer writes.
// Optional DRAW watchdog (abort + sticky timeout) is built when LINE_ARB_TIMEOUT_EN is defined.
module line_draw_arbiter #(
  parameter int N          = 2,
  parameter int W          = 11,
  parameter int MAX_PIXELS = 2048
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_x0,
  input  logic [N*W-1:0] req_y0,
  input  logic [N*W-1:0] req_x1,
  input  logic [N*W-1:0] req_y1,
  input  logic [N-1:0]   req_color,
  output logic [N-1:0]   done,
  output logic           drawer_reset,
  output logic [W-1:0]   drawer_x0,
  output logic [W-1:0]   drawer_y0,
  output logic [W-1:0]   drawer_x1,
  output logic [W-1:0]   drawer_y1,
  input  logic [W-1:0]   drawer_x,
  input  logic [W-1:0]   drawer_y,
  output logic [W-1:0]   pixel_x,
  output logic [W-1:0]   pixel_y,
  output logic           pixel_color,
  output logic           pixel_we,
  output logic           busy,
  output logic           timeout,
  output logic [1:0]     dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [W-1:0]    x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic            color_q, color_d;
  logic [N-1:0]    done_q, done_d;
  logic [N-1:0]    grant_oh;
  logic [PW-1:0]   grant_idx;
  logic            found;
  int              scan_idx;
  logic            pixel_we_c;
  logic            hit;

`ifdef LINE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_PIXELS + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic            unused_cfg;
  assign unused_cfg = ^MAX_PIXELS;
`endif

  // Handshake: a command transfers in the cycle req_valid[i] & req_ready[i]; ready is a
  // combinational one-hot grant that exists only in IDLE, so no command is ever queued.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!found && req_valid[scan_idx]) begin
        found              = 1'b1;
        grant_oh[scan_idx] = 1'b1;
        grant_idx          = scan_idx[PW-1:0];
      end
    end
  end

  assign hit = (drawer_x == x1_q) && (drawer_y == y1_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    done_d     = '0;
    pixel_we_c = 1'b0;
`ifdef LINE_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d    = grant_idx;
          x0_d     = req_x0[grant_idx*W +: W];
          y0_d     = req_y0[grant_idx*W +: W];
          x1_d     = req_x1[grant_idx*W +: W];
          y1_d     = req_y1[grant_idx*W +: W];
          color_d  = req_color[grant_idx];
          rr_ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
`ifdef LINE_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = DRAW;
      end
      DRAW: begin
`ifdef LINE_ARB_TIMEOUT_EN
        // The abort cycle writes nothing; the owner still gets its done pulse.
        if (cnt_q == CW'(MAX_PIXELS)) begin
          state_d       = IDLE;
          done_d[gnt_q] = 1'b1;
          timeout_d     = 1'b1;
        end else begin
          pixel_we_c = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (hit) begin
            state_d       = IDLE;
            done_d[gnt_q] = 1'b1;
          end
        end
`else
        pixel_we_c = 1'b1;
        if (hit) begin
          state_d       = IDLE;
          done_d[gnt_q] = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= 1'b0;
      done_q    <= '0;
`ifdef LINE_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      color_q   <= color_d;
      done_q    <= done_d;
`ifdef LINE_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

`ifdef LINE_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign req_ready    = (state_q == IDLE && reset_n) ? grant_oh : '0;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);
  assign drawer_reset = (state_q == LOAD);
  assign drawer_x0    = x0_q;
  assign drawer_y0    = y0_q;
  assign drawer_x1    = x1_q;
  assign drawer_y1    = y1_q;
  assign pixel_we     = pixel_we_c;
  assign pixel_x      = pixel_we_c ? drawer_x : '0;
  assign pixel_y      = pixel_we_c ? drawer_y : '0;
  assign pixel_color  = pixel_we_c & color_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_line_draw_arbiter.sv
// tb_line_draw_arbiter: table-driven line vectors plus directed round-robin, hold-off, reset and
// watchdog sequences against a Bresenham line_drawer model.
module tb_line_draw_arbiter;
  localparam int N  = 2;
  localparam int W  = 11;
  localparam int MP = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_ready, req_color, done;
  logic [N*W-1:0] req_x0, req_y0, req_x1, req_y1;
  logic           drawer_reset;
  logic [W-1:0]   drawer_x0, drawer_y0, drawer_x1, drawer_y1;
  logic [W-1:0]   mdl_x, mdl_y;
  logic [W-1:0]   pixel_x, pixel_y;
  logic           pixel_color, pixel_we, busy, timeout;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit stuck    = 1'b0;

  line_draw_arbiter #(.N(N), .W(W), .MAX_PIXELS(MP)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_color(req_color), .done(done),
    .drawer_reset(drawer_reset),
    .drawer_x0(drawer_x0), .drawer_y0(drawer_y0), .drawer_x1(drawer_x1), .drawer_y1(drawer_y1),
    .drawer_x(mdl_x), .drawer_y(mdl_y),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color), .pixel_we(pixel_we),
    .busy(busy), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  // ---------------- line_drawer model (Bresenham, one pixel per clock) ----------------
  int m_dx, m_dy, m_sx, m_sy, m_err, m_e2, m_errn;
  always @(posedge clk) begin
    if (drawer_reset) begin
      mdl_x <= drawer_x0;
      mdl_y <= drawer_y0;
      m_dx  <= (drawer_x1 >= drawer_x0) ? int'(drawer_x1 - drawer_x0) : int'(drawer_x0 - drawer_x1);
      m_dy  <= (drawer_y1 >= drawer_y0) ? -int'(drawer_y1 - drawer_y0) : -int'(drawer_y0 - drawer_y1);
      m_sx  <= (drawer_x1 >= drawer_x0) ? 1 : -1;
      m_sy  <= (drawer_y1 >= drawer_y0) ? 1 : -1;
      m_err <= ((drawer_x1 >= drawer_x0) ? int'(drawer_x1 - drawer_x0) : int'(drawer_x0 - drawer_x1))
             - ((drawer_y1 >= drawer_y0) ? int'(drawer_y1 - drawer_y0) : int'(drawer_y0 - drawer_y1));
    end else if (!stuck && !(mdl_x == drawer_x1 && mdl_y == drawer_y1)) begin
      m_e2   = 2 * m_err;
      m_errn = m_err;
      if (m_e2 >= m_dy) begin
        m_errn = m_errn + m_dy;
        mdl_x <= mdl_x + W'(m_sx);
      end
      if (m_e2 <= m_dx) begin
        m_errn = m_errn + m_dx;
        mdl_y <= mdl_y + W'(m_sy);
      end
      m_err <= m_errn;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1, input logic c);
    req_x0[r*W +: W] = x0;
    req_y0[r*W +: W] = y0;
    req_x1[r*W +: W] = x1;
    req_y1[r*W +: W] = y1;
    req_color[r]     = c;
  endtask

  task automatic do_reset();
    next_cycle();
    reset_n   = 1'b0;
    req_valid = '0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input logic [N-1:0] exp_done, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      sample();
      if (done != '0) begin
        got = 1'b1;
        chk({name, "_done"}, done, exp_done);
      end
      next_cycle();
    end
    if (!got) chk({name, "_done_timeout"}, 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         r;
    logic [W-1:0] x0, y0, x1, y1;
    logic       c;
    int         writes;
  } vec_t;

  vec_t vecs[5];

  task automatic run_line(input int vi, input vec_t v);
    logic [N-1:0] exp_oh;
    int writes, first_cyc, last_cyc;
    logic [W-1:0] fx, fy, lx, ly;
    bit got_done, color_bad;
    string tag;
    tag = $sformatf("vec%0d", vi);
    exp_oh = '0;
    exp_oh[v.r] = 1'b1;
    next_cycle();
    req_valid = exp_oh;
    set_req(v.r, v.x0, v.y0, v.x1, v.y1, v.c);
    sample();
    chk({tag, "_ready"}, req_ready, exp_oh);
    next_cycle();
    req_valid = '0;
    req_x1[v.r*W +: W] = ~v.x1;
    req_color[v.r]     = ~v.c;
    sample();
    chk({tag, "_drawer_reset"}, {drawer_reset, busy, pixel_we}, 3'b110);
    chk({tag, "_endpoint"}, {drawer_x1, drawer_y1}, {v.x1, v.y1});
    writes = 0; got_done = 0; color_bad = 0; first_cyc = -1; last_cyc = -1;
    fx = '0; fy = '0; lx = '0; ly = '0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      next_cycle();
      sample();
      if (pixel_we) begin
        if (writes == 0) begin
          fx = pixel_x; fy = pixel_y; first_cyc = cyc;
        end
        lx = pixel_x; ly = pixel_y; last_cyc = cyc;
        if (pixel_color !== v.c) color_bad = 1'b1;
        writes++;
      end
      if (done != '0) begin
        got_done = 1'b1;
        chk({tag, "_done_onehot"}, done, exp_oh);
        chk({tag, "_done_latency"}, cyc, last_cyc + 1);
        chk({tag, "_busy_at_done"}, busy, 0);
      end
    end
    if (!got_done) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_first_latency"}, first_cyc, 0);
    chk({tag, "_writes"}, writes, v.writes);
    chk({tag, "_first_px"}, {fx, fy}, {v.x0, v.y0});
    chk({tag, "_last_px"}, {lx, ly}, {v.x1, v.y1});
    chk({tag, "_color"}, color_bad, 0);
    next_cycle();
    sample();
    chk({tag, "_done_width"}, done, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0] exp_q[$];
  logic [N-1:0] done_exp_q[$];

  initial begin
    int accepts, idle_run, max_idle, dones;
    bit early;
    logic [N-1:0] e;

    vecs[0] = '{r: 0, x0: 11'd0,    y0: 11'd0,   x1: 11'd10,   y1: 11'd15, c: 1'b1, writes: 16};
    vecs[1] = '{r: 1, x0: 11'd5,    y0: 11'd5,   x1: 11'd5,    y1: 11'd5,  c: 1'b0, writes: 1};
    vecs[2] = '{r: 0, x0: 11'd20,   y0: 11'd3,   x1: 11'd2,    y1: 11'd7,  c: 1'b1, writes: 19};
    vecs[3] = '{r: 1, x0: 11'd2047, y0: 11'd0,   x1: 11'd2040, y1: 11'd2,  c: 1'b1, writes: 8};
    vecs[4] = '{r: 0, x0: 11'd0,    y0: 11'd100, x1: 11'd0,    y1: 11'd90, c: 1'b0, writes: 11};

    reset_n = 1'b0;
    req_valid = 2'b11;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0; req_color = '0;
    repeat (3) next_cycle();
    sample();
    chk("reset_outputs", {req_ready, done, pixel_we, drawer_reset, busy, pixel_color, timeout}, 0);
    chk("reset_drawer_endpoints", {drawer_x0, drawer_y0, drawer_x1, drawer_y1, pixel_x, pixel_y}, 0);
    chk("reset_state", dbg_state, 0);
    next_cycle();
    req_valid = '0;
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) run_line(i, vecs[i]);

    // Round robin with both requesters valid continuously.
    do_reset();
    set_req(0, 11'd0, 11'd0, 11'd2, 11'd0, 1'b1);
    set_req(1, 11'd9, 11'd9, 11'd9, 11'd9, 1'b0);
    req_valid = 2'b11;
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    accepts = 0; idle_run = 0; max_idle = 0; dones = 0;
    for (int i = 0; i < 200 && accepts < 4; i++) begin
      sample();
      if (done != '0) begin
        dones++;
        if (done_exp_q.size() > 0) chk("rr_done_order", done, done_exp_q.pop_front());
        else chk("rr_done_unexpected", done, 0);
      end
      if (accepts > 0) begin
        idle_run = busy ? 0 : idle_run + 1;
        if (idle_run > max_idle) max_idle = idle_run;
      end
      if (req_ready != '0) begin
        e = exp_q.pop_front();
        chk($sformatf("rr_grant%0d", accepts), req_ready, e);
        done_exp_q.push_back(e);
        accepts++;
      end
      next_cycle();
    end
    req_valid = '0;
    chk("rr_accepts", accepts, 4);
    chk("rr_busy_gap", max_idle, 1);
    wait_done("rr_last", 2'b10, 20);
    chk("rr_done_count", dones + 1, 4);

    // Hold-off: req1 arrives during req0's line and is granted on done[0].
    do_reset();
    set_req(0, 11'd0, 11'd0, 11'd4, 11'd0, 1'b1);
    req_valid = 2'b01;
    sample();
    chk("hold_grant0", req_ready, 2'b01);
    next_cycle();
    set_req(1, 11'd1, 11'd1, 11'd1, 11'd1, 1'b1);
    req_valid = 2'b10;
    early = 1'b0;
    e = '0;
    for (int i = 0; i < 50 && e == '0; i++) begin
      sample();
      if (done[0]) begin
        e = req_ready;
        chk("hold_grant_at_done", req_ready, 2'b10);
      end else if (req_ready != '0) begin
        early = 1'b1;
      end
      next_cycle();
    end
    chk("hold_no_early_ready", early, 0);
    req_valid = '0;
    sample();
    chk("hold_req1_load", {drawer_reset, drawer_x0, drawer_y0}, {1'b1, 11'd1, 11'd1});
    next_cycle();
    wait_done("hold_req1", 2'b10, 20);

    // Reset in the middle of a long line.
    set_req(0, 11'd0, 11'd0, 11'd100, 11'd0, 1'b1);
    req_valid = 2'b01;
    next_cycle();
    req_valid = '0;
    repeat (10) next_cycle();
    sample();
    chk("midreset_drawing", pixel_we, 1);
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    sample();
    chk("midreset_outputs", {pixel_we, busy, done, drawer_reset, pixel_x, drawer_x1}, 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      sample();
      if (done != '0) dones++;
    end
    chk("midreset_no_done", dones, 0);
    next_cycle();
    set_req(0, 11'd1, 11'd2, 11'd1, 11'd2, 1'b0);
    set_req(1, 11'd3, 11'd3, 11'd3, 11'd3, 1'b0);
    req_valid = 2'b11;
    sample();
    chk("midreset_rr_ptr", req_ready, 2'b01);
    next_cycle();
    req_valid = '0;
    wait_done("midreset_after", 2'b01, 20);

`ifdef LINE_ARB_TIMEOUT_EN
    // Watchdog: the drawer never advances, so the line must abort after MP writes.
    stuck = 1'b1;
    set_req(1, 11'd0, 11'd0, 11'd3, 11'd3, 1'b1);
    req_valid = 2'b10;
    next_cycle();
    req_valid = '0;
    dones = 0;
    accepts = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      sample();
      if (pixel_we) accepts++;
      if (done != '0) begin
        dones++;
        chk("wd_done", done, 2'b10);
        chk("wd_timeout_set", timeout, 1);
      end
      next_cycle();
    end
    chk("wd_writes", accepts, MP);
    chk("wd_done_seen", dones, 1);
    stuck = 1'b0;
    set_req(0, 11'd4, 11'd4, 11'd4, 11'd4, 1'b0);
    req_valid = 2'b01;
    next_cycle();
    req_valid = '0;
    wait_done("wd_next_line", 2'b01, 20);
    sample();
    chk("wd_timeout_sticky", timeout, 1);
    do_reset();
    sample();
    chk("wd_timeout_cleared", timeout, 0);
`else
    sample();
    chk("timeout_tied_low", timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
